// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard detection and pipeline register control for the 5-stage core
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_uses_hilo,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_mdu_start,
  input  logic       ex_mdu_is_div,
  input  logic       ex_branch_taken,
  input  logic       mem_stall,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_we,
  output logic       idex_flush,
  output logic       exmem_we,
  output logic       exmem_flush,
  output logic       memwb_we,
  output logic       memwb_flush,
  output logic       mdu_busy
);

  typedef enum logic {IDLE, BUSY} mdu_state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             load_use;
  logic             mdu_hold;

  // A start in either state (re)loads the full occupancy; mem_stall does not pause the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (ex_mdu_start) begin
      state <= BUSY;
      cnt   <= ex_mdu_is_div ? DIV_LOAD : MUL_LOAD;
    end else if (state == BUSY) begin
      if (cnt == '0) begin
        state <= IDLE;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign mdu_busy = (state == BUSY);

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  assign mdu_hold = mdu_busy && id_uses_hilo;

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_we     = 1'b1;
    idex_flush  = 1'b0;
    exmem_we    = 1'b1;
    exmem_flush = 1'b0;
    memwb_we    = 1'b1;
    memwb_flush = 1'b0;
    if (!rst_n) begin
      // Registers clear on the reset edge, so every flush is asserted with its we.
      pc_we       = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (mem_stall) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use || mdu_hold) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  // Output pattern order: pc_we, ifid we/flush, idex we/flush, exmem we/flush, memwb we/flush.
  localparam logic [8:0] P_RESET  = 9'b0_11_11_11_11;
  localparam logic [8:0] P_FREEZE = 9'b0_00_00_00_00;
  localparam logic [8:0] P_BRANCH = 9'b1_11_11_10_10;
  localparam logic [8:0] P_BUBBLE = 9'b0_00_11_10_10;
  localparam logic [8:0] P_NORMAL = 9'b1_10_10_10_10;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic id_uses_rs, id_uses_rt, id_uses_hilo;
  logic ex_mem_read, ex_mdu_start, ex_mdu_is_div, ex_branch_taken, mem_stall;
  logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
  logic exmem_we, exmem_flush, memwb_we, memwb_flush, mdu_busy;

  int total = 0;
  int bad = 0;
  int busy_left = 0;
  logic [8:0] s_out;
  logic s_busy;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_uses_hilo(id_uses_hilo), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_mdu_start(ex_mdu_start), .ex_mdu_is_div(ex_mdu_is_div),
    .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_we(idex_we), .idex_flush(idex_flush),
    .exmem_we(exmem_we), .exmem_flush(exmem_flush),
    .memwb_we(memwb_we), .memwb_flush(memwb_flush), .mdu_busy(mdu_busy)
  );

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic urs, urt, mread, br, mstall;
    logic [8:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_ctrl();
    bit lu, hold;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    hold = (busy_left > 0) && id_uses_hilo;
    if (!rst_n) return P_RESET;
    if (mem_stall) return P_FREEZE;
    if (ex_branch_taken) return P_BRANCH;
    if (lu || hold) return P_BUBBLE;
    return P_NORMAL;
  endfunction

  // Called at posedge+1: check mid-cycle, then advance the model across the next edge.
  task automatic step(input string tag);
    #4;
    s_out  = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
              exmem_we, exmem_flush, memwb_we, memwb_flush};
    s_busy = mdu_busy;
    chk({tag, "_ctrl"}, 32'(s_out), 32'(model_ctrl()));
    chk({tag, "_busy"}, 32'(s_busy), 32'(busy_left > 0));
    @(posedge clk);
    if (!rst_n) busy_left = 0;
    else if (ex_mdu_start) busy_left = ex_mdu_is_div ? DIV_N : MUL_N;
    else if (busy_left > 0) busy_left--;
    #1;
  endtask

  task automatic quiet();
    rst_n = 1; id_rs = 0; id_rt = 0; ex_rd = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_uses_hilo = 0;
    ex_mem_read = 0; ex_mdu_start = 0; ex_mdu_is_div = 0;
    ex_branch_taken = 0; mem_stall = 0;
  endtask

  // Launch an MDU op with a hilo reader in ID, return busy and stalled cycle counts.
  task automatic run_mdu(input bit is_div, input string tag, output int busy_n, output int stall_n);
    busy_n = 0; stall_n = 0;
    ex_mdu_start = 1; ex_mdu_is_div = is_div; id_uses_hilo = 1;
    step({tag, "_start"});
    ex_mdu_start = 0;
    for (int i = 0; i < 40; i++) begin
      step(tag);
      if (!s_busy) break;
      busy_n++;
      if (s_out[8] == 1'b0) stall_n++;
    end
    chk({tag, "_release_pc"}, 32'(s_out[8]), 32'd1);
  endtask

  vec_t vecs[10];
  int bn, sn;

  initial begin
    quiet();
    rst_n = 0;
    @(posedge clk); #1;
    step("reset");
    chk("reset_pattern", 32'(s_out), 32'(P_RESET));
    quiet();
    step("post_reset");

    vecs[0] = '{8, 0, 8, 1, 0, 1, 0, 0, P_BUBBLE};
    vecs[1] = '{0, 8, 8, 0, 1, 1, 0, 0, P_BUBBLE};
    vecs[2] = '{0, 0, 0, 1, 1, 1, 0, 0, P_NORMAL};
    vecs[3] = '{8, 8, 8, 0, 0, 1, 0, 0, P_NORMAL};
    vecs[4] = '{8, 3, 9, 1, 1, 1, 0, 0, P_NORMAL};
    vecs[5] = '{8, 0, 8, 1, 0, 0, 0, 0, P_NORMAL};
    vecs[6] = '{8, 0, 8, 1, 0, 1, 1, 0, P_BRANCH};
    vecs[7] = '{8, 0, 8, 1, 0, 1, 1, 1, P_FREEZE};
    vecs[8] = '{1, 2, 3, 1, 1, 0, 1, 0, P_BRANCH};
    vecs[9] = '{31, 5, 31, 1, 1, 1, 0, 0, P_BUBBLE};
    foreach (vecs[i]) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_rd = vecs[i].rd;
      id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt;
      ex_mem_read = vecs[i].mread; ex_branch_taken = vecs[i].br; mem_stall = vecs[i].mstall;
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_table", i), 32'(s_out), 32'(vecs[i].exp));
    end

    // Load-use lasts one cycle: the load moves on and the hazard clears.
    quiet();
    ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
    step("lu_stall");
    chk("lu_stall_pattern", 32'(s_out), 32'(P_BUBBLE));
    quiet();
    step("lu_after");
    chk("lu_after_pattern", 32'(s_out), 32'(P_NORMAL));

    quiet();
    step("hilo_idle");
    id_uses_hilo = 1;
    step("hilo_idle2");
    chk("hilo_no_stall", 32'(s_out), 32'(P_NORMAL));

    quiet();
    run_mdu(1, "div", bn, sn);
    chk("div_busy_cycles", 32'(bn), 32'(DIV_N));
    chk("div_stall_cycles", 32'(sn), 32'(DIV_N));
    quiet();
    run_mdu(0, "mul", bn, sn);
    chk("mul_busy_cycles", 32'(bn), 32'(MUL_N));
    chk("mul_stall_cycles", 32'(sn), 32'(MUL_N));

    // Reload while busy: with cnt at 5, a new start restarts the full divide latency.
    quiet();
    ex_mdu_start = 1; ex_mdu_is_div = 1;
    step("reload_first");
    ex_mdu_start = 0;
    for (int i = 0; i < 26; i++) step("reload_wait");
    run_mdu(1, "reload", bn, sn);
    chk("reload_busy_cycles", 32'(bn), 32'(DIV_N));

    // Freeze with a pending load-use and branch while a multiply counts down.
    quiet();
    ex_mdu_start = 1;
    step("frz_start");
    quiet();
    mem_stall = 1; ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
    for (int i = 0; i < 3; i++) begin
      step("frz");
      chk("frz_pattern", 32'(s_out), 32'(P_FREEZE));
    end
    mem_stall = 0;
    step("frz_release");
    chk("frz_branch_flush", 32'(s_out), 32'(P_BRANCH));
    chk("frz_busy_last", 32'(s_busy), 32'd1);
    quiet();
    step("frz_done");
    chk("frz_busy_done", 32'(s_busy), 32'd0);

    // Reset during a divide aborts it.
    quiet();
    ex_mdu_start = 1; ex_mdu_is_div = 1;
    step("rstdiv_start");
    ex_mdu_start = 0; id_uses_hilo = 1;
    for (int i = 0; i < 10; i++) step("rstdiv_busy");
    rst_n = 0;
    step("rstdiv_reset");
    chk("rstdiv_reset_pattern", 32'(s_out), 32'(P_RESET));
    rst_n = 1;
    step("rstdiv_after");
    chk("rstdiv_busy_clear", 32'(s_busy), 32'd0);
    chk("rstdiv_no_stall", 32'(s_out[8]), 32'd1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(63) != 0);
      id_rs = 5'($urandom_range(3)); id_rt = 5'($urandom_range(3)); ex_rd = 5'($urandom_range(3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom); id_uses_hilo = 1'($urandom);
      ex_mem_read = 1'($urandom);
      ex_mdu_start = ($urandom_range(15) == 0);
      ex_mdu_is_div = ($urandom_range(3) == 0);
      ex_branch_taken = ($urandom_range(5) == 0);
      mem_stall = ($urandom_range(4) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard and pipeline-control unit for the 5-stage MIPS core. It drives the write-enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC write-enable. It detects load-use hazards, branch/jump redirects and memory stalls. It also tracks multi-cycle MUL/DIV occupancy with an internal countdown state machine. It sits directly upstream of every pipeline register's control pins.

## Interface
- MUL_CYCLES, 4, MDU occupancy for multiply (≥1)
- DIV_CYCLES, 32, MDU occupancy for divide (≥1)
- CNT_W, 6, counter width; must hold max(MUL_CYCLES, DIV_CYCLES)-1
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs/rt
- id_uses_hilo  in  1  ID instruction is mfhi/mflo/mthi/mtlo or a mul/div
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_mdu_start  in  1  mul/div in EX launches the MDU this cycle
- ex_mdu_is_div  in  1  qualifies ex_mdu_start: 1=div, 0=mul
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_stall  in  1  data/instruction memory not ready
- pc_we  out  1  PC write enable
- ifid_we, ifid_flush  out  1 each
- idex_we, idex_flush  out  1 each
- exmem_we, exmem_flush  out  1 each
- memwb_we, memwb_flush  out  1 each
- mdu_busy  out  1  MDU occupied (registered state)

## Operation
- Pipeline registers apply flush only when their we is high. Every flush driven here is therefore paired with we=1 on the same register.
- FSM states: IDLE, BUSY. Counter cnt is CNT_W bits.
- IDLE → BUSY on ex_mdu_start. cnt loads (ex_mdu_is_div ? DIV_CYCLES : MUL_CYCLES)-1.
- BUSY: cnt==0 → IDLE; otherwise cnt decrements.
- ex_mdu_start in BUSY reloads cnt and stays BUSY. Normal flow never produces this.
- mdu_busy = (state==BUSY).
- The FSM counts regardless of mem_stall.
- load_use = ex_mem_read & ex_rd≠0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- mdu_hold = mdu_busy & id_uses_hilo.
- Control outputs are combinational from inputs and state. Priority, highest first:
  1. mem_stall: all we=0, all flush=0, pc_we=0 (full freeze).
  2. ex_branch_taken: pc_we=1; ifid_we=1, ifid_flush=1; idex_we=1, idex_flush=1; exmem/memwb we=1, flush=0.
  3. load_use | mdu_hold: pc_we=0; ifid_we=0; idex_we=1, idex_flush=1 (bubble); exmem/memwb we=1, flush=0.
  4. Otherwise: all we=1, all flush=0, pc_we=1.
- A branch overrides a simultaneous hazard because the stalled ID instruction is being squashed.
- While rst_n=0:
  - all *_we=1, all *_flush=1, pc_we=0 (pipeline registers clear on the reset edge);
  - state←IDLE, cnt←0, mdu_busy=0.

## Timing
- Hazard outputs have zero latency: same cycle as the triggering inputs.
- MDU start accepted at edge E (instruction in EX). mdu_busy is high for exactly N cycles after E, where N=MUL_CYCLES or DIV_CYCLES. It drops after edge E+N.
- A hilo-dependent instruction in ID stalls for all N busy cycles. It advances into EX at edge E+N+1.
- A load-use stall lasts exactly one cycle. The load has moved to MEM at the next edge, so load_use falls.
- A stall held under mem_stall resumes the cycle mem_stall drops, with state unchanged except the counter.
- An ex_branch_taken blocked by mem_stall repeats because EX is frozen, so the flush occurs when mem_stall drops.
- rst_n low mid-BUSY aborts the MDU: IDLE at the next edge, no residual stall.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=8; id_rs=8, id_uses_rs=1 → one cycle of pc_we=0, ifid_we=0, idex_we=1, idex_flush=1. Next cycle all we=1, flush=0. Repeat with ex_rd=0 → no stall.
- Divide: ex_mdu_start=1, ex_mdu_is_div=1 at edge E → mdu_busy high for 32 cycles. With id_uses_hilo=1 throughout, pc_we=0 for those 32 cycles and 1 on the 33rd. Multiply gives 4 cycles.
- Branch vs hazard: ex_branch_taken=1 together with load_use=1 → pc_we=1, ifid_flush=idex_flush=1 with ifid_we=idex_we=1.
- Memory freeze: mem_stall=1 for 3 cycles during a load-use and a branch → all we=0 and pc_we=0 for 3 cycles. The branch flush then occurs on the first cycle after mem_stall falls. The MDU counter keeps decrementing during the freeze.
- Reset mid-divide: rst_n=0 at cycle 10 of BUSY → during reset all we=1, flush=1, pc_we=0. After release mdu_busy=0 and id_uses_hilo=1 causes no stall.
- Independence: id_uses_hilo=1 with mdu_busy=0 → no stall. ex_mdu_start pulse while BUSY with cnt=5 → cnt reloads and mdu_busy extends by the full latency.
